// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard unit (load-use stall, branch flush, forwarding, MUL/DIV sequencing)
// ports: rs*/Rd*/RegWrite*/ResultSrcE/PCSrcE/MulDivE/md_done in; StallF/StallD/StallE,
//        FlushD/FlushE/FlushM, ForwardAE/BE, md_start/md_err pulses, stall_cycles counter out
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_regD,
  input  logic [4:0]       rs2_regD,
  input  logic [4:0]       rs1_regE,
  input  logic [4:0]       rs2_regE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             md_done,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             md_start,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             md_stall, lw_stall;
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == rs1_regE) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == rs1_regE) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == rs2_regE) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == rs2_regE) ? 2'b01 : 2'b00;
    lw_stall = (ResultSrcE == 2'b01) && RdE != 5'd0 && (RdE == rs1_regD || RdE == rs2_regD);
  end
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    md_start = 1'b0;
    md_err   = 1'b0;
    md_stall = 1'b0;
    if (state_q == IDLE) begin
      if (MulDivE) begin
        md_start = 1'b1;
        md_stall = 1'b1;
        state_d  = BUSY;
        tmo_d    = '0;
      end
    end else if (md_done) begin
      state_d = IDLE;
    end else if (tmo_q == TW'(MD_TIMEOUT - 1)) begin
      md_err  = 1'b1;
      state_d = IDLE;
    end else begin
      md_stall = 1'b1;
      tmo_d    = tmo_q + TW'(1);
    end
    // reset mid-operation must not emit pulses or hold the pipe in the reset cycle
    if (rst) begin
      md_start = 1'b0;
      md_err   = 1'b0;
      md_stall = 1'b0;
    end
  end
  // a busy MUL/DIV keeps its instruction in E, so flushes wait until it finishes
  always_comb begin
    StallF = lw_stall | md_stall;
    StallD = lw_stall | md_stall;
    StallE = md_stall;
    FlushM = md_stall;
    FlushD = PCSrcE & ~md_stall;
    FlushE = (lw_stall | PCSrcE) & ~md_stall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (StallF && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl stalls, flushes, forwarding and MUL/DIV FSM
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_regD, rs2_regD, rs1_regE, rs2_regE, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        RegWriteM, RegWriteW, PCSrcE, MulDivE, md_done;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start, md_err;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cycles;
  logic        s_StallF, s_StallD, s_StallE, s_FlushD, s_FlushE, s_FlushM, s_md_start, s_md_err;
  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic [1:0]  sat_cycles;
  logic [7:0]  ctl;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_sc = 0;
  always #5 clk = ~clk;
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start, md_err};
  hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_regD(rs1_regD), .rs2_regD(rs2_regD), .rs1_regE(rs1_regE),
    .rs2_regE(rs2_regE), .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .md_done(md_done), .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .md_start(md_start), .md_err(md_err), .stall_cycles(stall_cycles));
  hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rs1_regD(rs1_regD), .rs2_regD(rs2_regD), .rs1_regE(rs1_regE),
    .rs2_regE(rs2_regE), .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .md_done(md_done), .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .FlushD(s_FlushD),
    .FlushE(s_FlushE), .FlushM(s_FlushM), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .md_start(s_md_start), .md_err(s_md_err), .stall_cycles(sat_cycles));
  task automatic clear_inputs();
    {rs1_regD, rs2_regD, rs1_regE, rs2_regE, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {RegWriteM, RegWriteW, PCSrcE, MulDivE, md_done} = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL reset_ctl got %b exp %b", ctl, 8'h00); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", stall_cycles); end
    RegWriteM = 1'b1; RdM = 5'd7; rs1_regE = 5'd7;
    #1;
    n_cmp++; if (ForwardAE !== 2'b10) begin n_bad++; $display("FAIL reset_fwd got %b exp 10", ForwardAE); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask
  task automatic test_forward();
    @(negedge clk);
    RegWriteM = 1'b1; RdM = 5'd3; rs1_regE = 5'd3; rs2_regE = 5'd3; RegWriteW = 1'b1; RdW = 5'd3;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin n_bad++; $display("FAIL fwd_m_wins got %b exp 1010", {ForwardAE, ForwardBE}); end
    RegWriteM = 1'b0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0101) begin n_bad++; $display("FAIL fwd_w got %b exp 0101", {ForwardAE, ForwardBE}); end
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; rs1_regE = 5'd0; rs2_regE = 5'd0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_bad++; $display("FAIL fwd_x0 got %b exp 0000", {ForwardAE, ForwardBE}); end
    RdM = 5'd4; RdW = 5'd3; rs1_regE = 5'd3; rs2_regE = 5'd4;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin n_bad++; $display("FAIL fwd_mixed got %b exp 0110", {ForwardAE, ForwardBE}); end
    RegWriteW = 1'b0; rs2_regE = 5'd9;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_bad++; $display("FAIL fwd_none got %b exp 0000", {ForwardAE, ForwardBE}); end
    clear_inputs();
  endtask
  task automatic test_lwstall();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd5; rs1_regD = 5'd5;
    #1;
    n_cmp++; if (ctl !== 8'b11001000) begin n_bad++; $display("FAIL lw_rs1 got %b exp 11001000", ctl); end
    @(negedge clk);
    clear_inputs();
    RegWriteW = 1'b1; RdW = 5'd5; rs1_regE = 5'd5;
    exp_sc = exp_sc + 1;
    #1;
    n_cmp++; if ({ctl, ForwardAE} !== 10'b0000000001) begin n_bad++; $display("FAIL lw_after got %b exp 0000000001", {ctl, ForwardAE}); end
    n_cmp++; if (stall_cycles !== 32'(exp_sc)) begin n_bad++; $display("FAIL lw_cnt got %0d exp %0d", stall_cycles, exp_sc); end
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 5'd6; rs2_regD = 5'd6;
    #1;
    n_cmp++; if (ctl !== 8'b11001000) begin n_bad++; $display("FAIL lw_rs2 got %b exp 11001000", ctl); end
    @(negedge clk);
    exp_sc = exp_sc + 1;
    RdE = 5'd0; rs2_regD = 5'd0;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL lw_x0 got %b exp 00000000", ctl); end
    ResultSrcE = 2'b10; RdE = 5'd5; rs1_regD = 5'd5;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL lw_notload got %b exp 00000000", ctl); end
    clear_inputs();
  endtask
  task automatic test_muldiv();
    @(negedge clk);
    MulDivE = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'b11100110) begin n_bad++; $display("FAIL md_start got %b exp 11100110", ctl); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (ctl !== 8'b11100100) begin n_bad++; $display("FAIL md_busy%0d got %b exp 11100100", i, ctl); end
    end
    @(negedge clk);
    md_done = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL md_done got %b exp 00000000", ctl); end
    @(negedge clk);
    clear_inputs();
    exp_sc = exp_sc + 4;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL md_idle got %b exp 00000000", ctl); end
    n_cmp++; if (stall_cycles !== 32'(exp_sc)) begin n_bad++; $display("FAIL md_cnt got %0d exp %0d", stall_cycles, exp_sc); end
    n_cmp++; if (sat_cycles !== 2'((exp_sc > 3) ? 3 : exp_sc)) begin n_bad++; $display("FAIL md_sat got %0d exp 3", sat_cycles); end
  endtask
  task automatic test_timeout();
    @(negedge clk);
    MulDivE = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'b11100110) begin n_bad++; $display("FAIL to_start got %b exp 11100110", ctl); end
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ctl !== ((i < 64) ? 8'b11100100 : 8'b00000001)) begin
        n_bad++; $display("FAIL to_cycle%0d got %b", i, ctl);
      end
    end
    @(negedge clk);
    clear_inputs();
    exp_sc = exp_sc + 64;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL to_idle got %b exp 00000000", ctl); end
    n_cmp++; if (stall_cycles !== 32'(exp_sc)) begin n_bad++; $display("FAIL to_cnt got %0d exp %0d", stall_cycles, exp_sc); end
    n_cmp++; if (sat_cycles !== 2'd3) begin n_bad++; $display("FAIL to_sat got %0d exp 3", sat_cycles); end
  endtask
  task automatic test_flush_busy();
    @(negedge clk);
    MulDivE = 1'b1; PCSrcE = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'b11100110) begin n_bad++; $display("FAIL fb_start got %b exp 11100110", ctl); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (ctl !== 8'b11100100) begin n_bad++; $display("FAIL fb_busy%0d got %b exp 11100100", i, ctl); end
    end
    @(negedge clk);
    md_done = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'b00011000) begin n_bad++; $display("FAIL fb_deferred got %b exp 00011000", ctl); end
    @(negedge clk);
    clear_inputs();
    PCSrcE = 1'b1;
    exp_sc = exp_sc + 3;
    #1;
    n_cmp++; if (ctl !== 8'b00011000) begin n_bad++; $display("FAIL fb_idle_flush got %b exp 00011000", ctl); end
    n_cmp++; if (stall_cycles !== 32'(exp_sc)) begin n_bad++; $display("FAIL fb_cnt got %0d exp %0d", stall_cycles, exp_sc); end
    clear_inputs();
  endtask
  task automatic test_reset_busy();
    @(negedge clk);
    MulDivE = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (ctl !== 8'b11100100) begin n_bad++; $display("FAIL rb_busy got %b exp 11100100", ctl); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL rb_in_reset got %b exp 00000000", ctl); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    exp_sc = 0;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL rb_after got %b exp 00000000", ctl); end
    n_cmp++; if (stall_cycles !== 32'(exp_sc)) begin n_bad++; $display("FAIL rb_cnt got %0d exp 0", stall_cycles); end
    md_done = 1'b1;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL rb_done_idle got %b exp 00000000", ctl); end
    @(negedge clk);
    md_done = 1'b0;
    #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL rb_done_ignored got %b exp 00000000", ctl); end
  endtask
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_lwstall();
    test_muldiv();
    test_timeout();
    test_flush_busy();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
